uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 115 +++++++++++
 tb/tb_uart_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: a byte accepted in IDLE becomes a start / LSB-first data / optional parity / stop frame.
// Latency: TX_OUT shows the start bit on the acceptance edge; one bit per CLK. Backpressure: busy high; Data_Valid dropped.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;

        case (state_q)
            S_IDLE: begin
                if (Data_Valid) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register on the same edge as the FSM.
        tx_d   = 1'b1;
        busy_d = 1'b0;
        case (state_d)
            S_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            S_DATA: begin
                tx_d   = data_d[cnt_d];
                busy_d = 1'b1;
            end
            S_PARITY: begin
                tx_d   = (^data_d) ^ par_typ_d;
                busy_d = 1'b1;
            end
            S_STOP: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: stimulus pushes the expected TX_OUT/busy of every cycle; a monitor pops and compares after each edge.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  tx;
        logic  bsy;
        string tag;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       ptyp;
        logic       exp_par;
        int         poke;
    } vec_t;

    vec_t vecs[8];

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (TX_OUT !== e.tx) begin
                    n_bad++;
                    $display("FAIL %s tx: got %b want %b", e.tag, TX_OUT, e.tx);
                end
                n_cmp++;
                if (busy !== e.bsy) begin
                    n_bad++;
                    $display("FAIL %s busy: got %b want %b", e.tag, busy, e.bsy);
                end
            end
        end
    end

    task automatic tick(input logic rst, input logic dv, input logic [7:0] d,
                        input logic pen, input logic ptyp,
                        input logic etx, input logic ebsy, input string tag);
        exp_t e;
        @(negedge CLK);
        RST        = rst;
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        e.tx  = etx;
        e.bsy = ebsy;
        e.tag = tag;
        sb.push_back(e);
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic pen,
                                       input logic par, input int i);
        if (i == 0)              return 1'b0;
        else if (i <= 8)         return d[i-1];
        else if (pen && i == 9)  return par;
        else                     return 1'b1;
    endfunction

    // Sends one frame from IDLE; on cycle 'poke' a competing request with inverted inputs is raised.
    task automatic run_frame(input vec_t v, input string tag);
        int  len;
        logic dv;
        len = v.pen ? 11 : 10;
        for (int i = 0; i < len; i++) begin
            dv = (i == 0) || (i == v.poke);
            if (i == 0)
                tick(1'b0, dv, v.data, v.pen, v.ptyp, frame_bit(v.data, v.pen, v.exp_par, i), 1'b1,
                     $sformatf("%s bit%0d", tag, i));
            else
                tick(1'b0, dv, ~v.data, ~v.pen, ~v.ptyp, frame_bit(v.data, v.pen, v.exp_par, i), 1'b1,
                     $sformatf("%s bit%0d", tag, i));
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, {tag, " idle"});
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, {tag, " idle2"});
    endtask

    initial begin : stim
        int spin;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, -1};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, -1};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, -1};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, -1};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0,  5};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, -1};
        vecs[6] = '{8'h07, 1'b1, 1'b0, 1'b1,  2};
        vecs[7] = '{8'h3C, 1'b1, 1'b0, 1'b0,  3};

        // Reset held with a pending request must keep the line idle.
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, $sformatf("reset%0d", i));
        for (int i = 0; i < 3; i++)
            tick(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("post_reset%0d", i));

        // The first no-parity frame 0xA5 is checked against the literal 10-bit pattern.
        begin
            logic [9:0] pat;
            pat = 10'b1101001010;
            for (int i = 0; i < 10; i++)
                tick(1'b0, i == 0, 8'hA5, 1'b0, 1'b0, pat[i], 1'b1, $sformatf("a5_lit bit%0d", i));
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "a5_lit idle");
        end

        for (int k = 0; k < 8; k++)
            run_frame(vecs[k], $sformatf("vec%0d", k));

        // Data_Valid held high: 10 frame bits then exactly one idle cycle, repeating.
        for (int i = 0; i < 33; i++) begin
            int j;
            j = i % 11;
            if (j == 10)
                tick(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("b2b c%0d", i));
            else
                tick(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, frame_bit(8'h55, 1'b0, 1'b0, j), 1'b1,
                     $sformatf("b2b c%0d", i));
        end
        for (int i = 0; i < 2; i++)
            tick(1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("b2b tail%0d", i));

        // Reset on the edge that would drive data bit 3 of 0x00 aborts the frame cleanly.
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "midrst start");
        for (int i = 1; i < 4; i++)
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("midrst bit%0d", i));
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "midrst rst");
        for (int i = 0; i < 12; i++)
            tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, $sformatf("midrst after%0d", i));

        spin = 0;
        while (sb.size() > 0 && spin < 20) begin
            @(negedge CLK);
            spin++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
